sustain_envelope: RTL and testbench
===================================

# sustain_envelope

Consumer of the sustain duration produced by `sustain_variation`. On each note start it latches the 16-bit sustain count for that note and runs an attack/sustain/release gain envelope, stepped on sample ticks. It scales the synthesized sample stream by that gain. It sits between the note sequencer/sustain_variation pair and the codec sample path.

## Interface
Parameters:
- `ATTACK_STEP`, 16: gain increment per sample tick in ATTACK (1..255).
- `RELEASE_STEP`, 4: gain decrement per sample tick in RELEASE (1..255).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `new_note`  in  1  one-cycle pulse; a new note starts this cycle.
- `note`  in  6  note index; 0 = rest.
- `sustain_count`  in  16  sustain length in sample ticks, from `sustain_variation`. Valid in the `new_note` cycle.
- `sample_tick`  in  1  one-cycle pulse at the sample rate.
- `sample_in`  in  16  signed sample; valid in the `sample_tick` cycle.
- `sample_out`  out  16  signed scaled sample, registered.
- `sample_valid`  out  1  one-cycle pulse; `sample_out` is updated.
- `gain`  out  8  current envelope gain, 0..255.
- `note_active`  out  1  high in ATTACK or SUSTAIN.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ATTACK, SUSTAIN, RELEASE. Internal 16-bit `sus_cnt`.
- `new_note` with `note`≠0, from any state:
  - `sus_cnt <= sustain_count`.
  - State goes to ATTACK.
  - `gain` is held; no reset to 0, so retriggers do not click.
- `new_note` with `note`==0, from any state: go to RELEASE. Already in IDLE: stay in IDLE.
- Transitions happen only on `sample_tick`, unless `new_note` is high in the same cycle.
- ATTACK: `gain <= min(gain+ATTACK_STEP, 255)`. When the new gain is 255:
  - go to SUSTAIN if `sus_cnt`≠0;
  - go to RELEASE if `sus_cnt`==0.
- SUSTAIN: gain is held at 255 and `sus_cnt` decrements. On the tick where `sus_cnt` goes 1→0, go to RELEASE. SUSTAIN therefore lasts exactly `sustain_count` ticks.
- RELEASE: `gain <= max(gain-RELEASE_STEP, 0)`. When the new gain is 0, go to IDLE.
- IDLE: gain is 0; ticks still produce output, which is 0.
- Arithmetic:
  - Compute with 9-bit unsigned intermediates, so gain saturates and never wraps.
  - The product is `sample_in` (signed 16) × {1'b0, gain} (signed 9), giving a 25-bit signed result.
  - `sample_out` = product >>> 8, truncated to 16 bits. This cannot overflow because gain ≤ 255.
- Simultaneous `new_note` and `sample_tick`:
  - `new_note` wins the state and `sus_cnt` update.
  - Gain does not step that tick.
  - The sample is still scaled with the pre-update gain and `sample_valid` still fires.
- `sustain_count` is sampled only in the `new_note` cycle. Later changes are ignored.

## Timing
- Reset values: state IDLE, `gain` 0, `sus_cnt` 0, `sample_out` 0, `sample_valid` 0, `note_active` 0, `busy` 0.
- Reset asserted mid-note: all outputs go to reset values immediately, without waiting for a clock edge.
- `sample_out`/`sample_valid`:
  - registered in the `sample_tick` cycle, using the gain value before that tick's update;
  - visible one cycle after the tick (latency 1);
  - `sample_valid` is high for exactly one cycle.
- `gain`, `note_active` and `busy` are registered. They change at the clock edge ending the tick or `new_note` cycle.
- Default parameters, full note from IDLE:
  - 16 ticks of ATTACK;
  - then `sustain_count` ticks of SUSTAIN;
  - then 64 ticks of RELEASE (255→3 after 63 ticks, 0 on the 64th), then IDLE.
- Back-to-back ticks every cycle are supported.

## Test plan
- Reset, then `new_note` with note=1 and sustain_count=3, ticks every 4 cycles → `gain` reads 16, 32, …, 240, 255 (SUSTAIN after tick 16). It holds 255 for 3 ticks, then 251, 247, … and reaches 0 / IDLE / `busy`=0 after 64 release ticks.
- During sustain, `sample_in`=32767 → `sample_out`=32639 one cycle after the tick. `sample_in`=−32768 → −32640. `sample_valid` is a single-cycle pulse.
- sustain_count=0 → ATTACK goes straight to RELEASE when gain hits 255. `note_active` falls on that same edge.
- Retrigger in RELEASE at gain=100 with sustain_count=5 → ATTACK resumes from 100 (next gain 116) and `sus_cnt`=5. With `new_note` and `sample_tick` in the same cycle, gain is not stepped but a sample is still output.
- `new_note` with note=0 during SUSTAIN → RELEASE from 255. `new_note` with note=0 in IDLE → remains IDLE.
- Assert reset asynchronously mid-ATTACK (between clock edges) → `gain`, `sample_out`, `busy` and `note_active` are 0 immediately. After release, `gain` stays 0 until the next `new_note`.

Source files
------------

// File: rtl/sustain_envelope.sv
// sustain_envelope: attack/sustain/release gain envelope driven by note starts,
// stepped on sample ticks, and applied to the synthesized sample stream.
//
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   new_note, note    note-start pulse and note index (0 = rest)
//   sustain_count     sustain length in sample ticks, sampled with new_note
//   sample_tick       sample-rate pulse; sample_in is valid with it
//   sample_in         signed input sample
//   sample_out        signed scaled sample, registered (latency 1)
//   sample_valid      one-cycle pulse when sample_out updates
//   gain              current envelope gain, 0..255
//   note_active       high in ATTACK or SUSTAIN
//   busy              high in any state other than IDLE
module sustain_envelope #(
   parameter int unsigned ATTACK_STEP  = 16,
   parameter int unsigned RELEASE_STEP = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               new_note,
   input  logic [5:0]         note,
   input  logic [15:0]        sustain_count,
   input  logic               sample_tick,
   input  logic signed [15:0] sample_in,
   output logic signed [15:0] sample_out,
   output logic               sample_valid,
   output logic [7:0]         gain,
   output logic               note_active,
   output logic               busy
);

   localparam int unsigned GW = 8;
   localparam int unsigned SW = 16;
   localparam int unsigned PW = 25;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ATTACK  = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [SW-1:0]     sus_cnt;
   logic [SW-1:0]     sus_nxt;
   logic [GW-1:0]     gain_nxt;
   logic [GW:0]       gain_up;
   logic [GW:0]       gain_dn;
   logic [GW-1:0]     gain_up_sat;
   logic [GW-1:0]     gain_dn_sat;
   logic signed [PW-1:0] product;
   logic              unused_product_bits;

   // Saturating gain steps: 9-bit intermediates so the carry/borrow is visible
   always_comb begin
      gain_up     = {1'b0, gain} + 9'(ATTACK_STEP);
      gain_dn     = {1'b0, gain} - 9'(RELEASE_STEP);
      gain_up_sat = gain_up[GW] ? 8'hFF : gain_up[GW-1:0];
      gain_dn_sat = gain_dn[GW] ? 8'h00 : gain_dn[GW-1:0];
   end

   // Sample scaling uses the gain currently held in the register (pre-update)
   always_comb begin
      product = 25'($signed(sample_in)) * 25'($signed({1'b0, gain}));
   end

   assign unused_product_bits = ^{product[PW-1:PW-1], product[7:0]};

   // Next-state logic; a note event takes priority over the tick step
   always_comb begin
      state_nxt = state;
      sus_nxt   = sus_cnt;
      gain_nxt  = gain;
      if (new_note) begin
         if (note != 6'd0) begin
            sus_nxt   = sustain_count;
            state_nxt = ATTACK;
         end else if (state != IDLE) begin
            state_nxt = RELEASE;
         end
      end else if (sample_tick) begin
         case (state)
            ATTACK: begin
               gain_nxt = gain_up_sat;
               if (gain_up_sat == 8'hFF)
                  state_nxt = (sus_cnt != 16'd0) ? SUSTAIN : RELEASE;
            end
            SUSTAIN: begin
               gain_nxt = 8'hFF;
               if (sus_cnt != 16'd0)
                  sus_nxt = sus_cnt - 16'd1;
               // Leave on the 1->0 tick so SUSTAIN lasts exactly sustain_count ticks
               if (sus_cnt <= 16'd1)
                  state_nxt = RELEASE;
            end
            RELEASE: begin
               gain_nxt = gain_dn_sat;
               if (gain_dn_sat == 8'h00)
                  state_nxt = IDLE;
            end
            default: begin
               gain_nxt = 8'h00;
            end
         endcase
      end
   end

   // Envelope state, gain and sample path registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         sus_cnt      <= '0;
         gain         <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         note_active  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         sus_cnt      <= sus_nxt;
         gain         <= gain_nxt;
         sample_valid <= sample_tick;
         if (sample_tick)
            sample_out <= product[23:8];
         note_active  <= (state_nxt == ATTACK) || (state_nxt == SUSTAIN);
         busy         <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_sustain_envelope.sv
// Directed bench for sustain_envelope: a spec-level envelope model predicts
// gain/state, and expected samples go through a scoreboard queue.
module tb_sustain_envelope;

   localparam int AS = 16;
   localparam int RS = 4;
   localparam int S_IDLE = 0, S_ATT = 1, S_SUS = 2, S_REL = 3;

   logic               clk;
   logic               reset;
   logic               new_note;
   logic [5:0]         note;
   logic [15:0]        sustain_count;
   logic               sample_tick;
   logic signed [15:0] sample_in;
   logic signed [15:0] sample_out;
   logic               sample_valid;
   logic [7:0]         gain;
   logic               note_active;
   logic               busy;

   int checks = 0;
   int errors = 0;
   int m_gain = 0;
   int m_st   = S_IDLE;
   int m_sus  = 0;
   logic signed [15:0] sb[$];

   sustain_envelope #(.ATTACK_STEP(AS), .RELEASE_STEP(RS)) dut (
      .clk(clk), .reset(reset), .new_note(new_note), .note(note),
      .sustain_count(sustain_count), .sample_tick(sample_tick),
      .sample_in(sample_in), .sample_out(sample_out),
      .sample_valid(sample_valid), .gain(gain),
      .note_active(note_active), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference envelope behaviour for one cycle
   task automatic model(input bit tk, input bit nn, input int nt, input int sc);
      if (nn) begin
         if (nt != 0) begin
            m_sus = sc;
            m_st  = S_ATT;
         end else if (m_st != S_IDLE) begin
            m_st = S_REL;
         end
      end else if (tk) begin
         case (m_st)
            S_ATT: begin
               m_gain = (m_gain + AS > 255) ? 255 : m_gain + AS;
               if (m_gain == 255) m_st = (m_sus != 0) ? S_SUS : S_REL;
            end
            S_SUS: begin
               m_sus = m_sus - 1;
               if (m_sus == 0) m_st = S_REL;
            end
            S_REL: begin
               m_gain = (m_gain - RS < 0) ? 0 : m_gain - RS;
               if (m_gain == 0) m_st = S_IDLE;
            end
            default: m_gain = 0;
         endcase
      end
   endtask

   task automatic step(input bit tk, input bit nn, input int nt, input int sc,
                       input int sin);
      int p;
      @(negedge clk);
      sample_tick   = tk;
      new_note      = nn;
      note          = nn ? 6'(nt) : 6'($urandom);
      sustain_count = nn ? 16'(sc) : 16'($urandom);
      sample_in     = tk ? 16'(sin) : 16'($urandom);
      if (tk) begin
         p = sin * m_gain;
         sb.push_back(16'(p >>> 8));
      end
      model(tk, nn, nt, sc);
      @(posedge clk);
      #1;
      sample_tick = 1'b0;
      new_note    = 1'b0;
      chk("sample_valid", 32'(sample_valid), 32'(tk));
      if (tk) begin
         if (sb.size() == 0) chk("sb_nonempty", sb.size(), 1);
         else chk("sample_out", sample_out, sb.pop_front());
      end
      chk("gain", 32'(gain), m_gain);
      chk("busy", 32'(busy), 32'(m_st != S_IDLE));
      chk("note_active", 32'(note_active), 32'(m_st == S_ATT || m_st == S_SUS));
   endtask

   // One tick followed by idle cycles
   task automatic tick(input int sin, input int gap);
      step(1'b1, 1'b0, 0, 0, sin);
      for (int i = 0; i < gap; i++) step(1'b0, 1'b0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b0; new_note = 1'b0; note = '0; sustain_count = '0;
      sample_tick = 1'b0; sample_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gain", 32'(gain), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_active", 32'(note_active), 0);
      chk("rst_valid", 32'(sample_valid), 0);
      chk("rst_sample", sample_out, 0);
      @(negedge clk);
      reset = 1'b1;

      // Full note: attack ramp, 3-tick sustain, 64-tick release
      step(1'b0, 1'b1, 1, 3, 0);
      for (int k = 1; k <= 16; k++) begin
         tick(int'($urandom_range(0, 65535)) - 32768, 3);
         chk("attack_ramp", 32'(gain), (k < 16) ? 16 * k : 255);
      end
      tick(32767, 0);
      chk("sus_pos", sample_out, 32639);
      step(1'b0, 1'b0, 0, 0, 0);
      chk("valid_pulse", 32'(sample_valid), 0);
      tick(-32768, 3);
      chk("sus_neg", sample_out, -32640);
      tick(12345, 3);
      chk("sus_end_active", 32'(note_active), 0);
      for (int k = 1; k <= 64; k++) begin
         tick(int'($urandom_range(0, 65535)) - 32768, 3);
         if (k == 1)  chk("rel_first", 32'(gain), 251);
         if (k == 63) chk("rel_63", 32'(gain), 3);
      end
      chk("rel_done_busy", 32'(busy), 0);
      chk("rel_done_gain", 32'(gain), 0);

      // sustain_count = 0: attack goes straight to release
      step(1'b0, 1'b1, 2, 0, 0);
      for (int k = 1; k <= 16; k++) tick(20000, 0);
      chk("sc0_active", 32'(note_active), 0);
      chk("sc0_busy", 32'(busy), 1);
      for (int k = 0; k < 70; k++) tick(-1000, 0);
      chk("sc0_idle", 32'(busy), 0);

      // Reach gain 100 in release: attack to 112, rest, release 3 ticks
      step(1'b0, 1'b1, 5, 9, 0);
      for (int k = 0; k < 7; k++) tick(500, 1);
      step(1'b0, 1'b1, 0, 0, 0);
      for (int k = 0; k < 3; k++) tick(-500, 1);
      chk("gain_100", 32'(gain), 100);
      // Retrigger together with a tick: gain holds, sample still produced
      step(1'b1, 1'b1, 7, 5, 25600);
      chk("retrig_sample", sample_out, 10000);
      chk("retrig_hold", 32'(gain), 100);
      tick(300, 0);
      chk("retrig_next", 32'(gain), 116);
      for (int k = 0; k < 9; k++) tick(300, 0);
      chk("retrig_peak", 32'(gain), 255);
      for (int k = 0; k < 4; k++) tick(-7, 0);
      chk("sus5_still", 32'(note_active), 1);
      tick(-7, 0);
      chk("sus5_end", 32'(note_active), 0);

      // note=0 during SUSTAIN releases from 255
      step(1'b0, 1'b1, 9, 10, 0);
      tick(100, 0);
      chk("sus_peak", 32'(gain), 255);
      tick(100, 0);
      step(1'b0, 1'b1, 0, 0, 0);
      chk("rest_active", 32'(note_active), 0);
      tick(100, 0);
      chk("rest_rel", 32'(gain), 251);
      for (int k = 0; k < 64; k++) tick(100, 0);
      chk("rest_idle", 32'(busy), 0);
      // note=0 in IDLE stays idle
      step(1'b0, 1'b1, 0, 0, 0);
      tick(4000, 0);
      chk("idle_rest", 32'(busy), 0);

      // Asynchronous reset mid-attack
      step(1'b0, 1'b1, 4, 7, 0);
      for (int k = 0; k < 5; k++) tick(1000, 0);
      chk("pre_rst_gain", 32'(gain), 80);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_gain", 32'(gain), 0);
      chk("arst_sample", sample_out, 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_active", 32'(note_active), 0);
      m_gain = 0; m_st = S_IDLE; m_sus = 0;
      sb.delete();
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) tick(3000, 1);
      chk("post_rst_gain", 32'(gain), 0);
      chk("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
